// File: rtl/freelist_ctrl.sv
// Physical-register free list: circular buffer of unallocated pregs.
// Grants up to FRONTEND_WIDTH pregs per cycle, reclaims released pregs at
// commit, and rewinds speculative allocations to the committed head on flush.
module freelist_ctrl #(
  parameter int unsigned FRONTEND_WIDTH      = 2,
  parameter int unsigned COMMIT_WIDTH        = 2,
  parameter int unsigned PHYS_REGS           = 64,
  parameter int unsigned PHYS_REGS_ADDR_SIZE = 6,
  parameter int unsigned ARCH_REGS           = 32
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [FRONTEND_WIDTH-1:0]                     alloc_req_i,
  output logic                                          alloc_ready_o,
  output logic [FRONTEND_WIDTH*PHYS_REGS_ADDR_SIZE-1:0] freelist_preg_o,
  input  logic [COMMIT_WIDTH-1:0]                       commit_alloc_v_i,
  input  logic [COMMIT_WIDTH-1:0]                       commit_free_v_i,
  input  logic [COMMIT_WIDTH*PHYS_REGS_ADDR_SIZE-1:0]   commit_free_preg_i,
  input  logic                                          flush_i,
  output logic [$clog2(PHYS_REGS-ARCH_REGS):0]          free_count_o,
  output logic                                          overflow_o
);

  localparam int unsigned DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int unsigned IW    = $clog2(DEPTH);
  localparam int unsigned PW    = IW + 1;
  localparam int unsigned PA    = PHYS_REGS_ADDR_SIZE;

  logic [PA-1:0] entry_q [DEPTH];
  logic [PA-1:0] entry_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] chead_q, chead_d;
  logic          overflow_q, overflow_d;

  logic [PW-1:0] count;
  logic [PW-1:0] n_req, n_rel, n_com;
  logic [PW-1:0] req_off [FRONTEND_WIDTH];
  logic [PW-1:0] rel_off [COMMIT_WIDTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   rel_total;

  // Prefix popcounts that compact requesting/releasing slots onto consecutive entries
  always_comb begin
    n_req = '0;
    for (int unsigned i = 0; i < FRONTEND_WIDTH; i++) begin
      req_off[i] = n_req;
      n_req      = n_req + PW'(alloc_req_i[i]);
    end
    n_rel = '0;
    for (int unsigned j = 0; j < COMMIT_WIDTH; j++) begin
      rel_off[j] = n_rel;
      n_rel      = n_rel + PW'(commit_free_v_i[j]);
    end
    n_com = '0;
    for (int unsigned j = 0; j < COMMIT_WIDTH; j++) begin
      n_com = n_com + PW'(commit_alloc_v_i[j]);
    end
  end

  assign count         = tail_q - head_q;
  assign alloc_ready_o = (count >= n_req) && !flush_i;
  assign free_count_o  = count;
  assign overflow_o    = overflow_q;

  // Lookahead grant per slot; shown even when not ready, zero for idle slots
  always_comb begin
    freelist_preg_o = '0;
    rd_ptr          = '0;
    for (int unsigned i = 0; i < FRONTEND_WIDTH; i++) begin
      rd_ptr = head_q + req_off[i];
      if (alloc_req_i[i]) begin
        freelist_preg_o[i*PA +: PA] = entry_q[rd_ptr[IW-1:0]];
      end
    end
  end

  // Next-state: releases, committed head, and head movement (flush beats grant)
  always_comb begin
    entry_d    = entry_q;
    wr_ptr     = '0;
    for (int unsigned j = 0; j < COMMIT_WIDTH; j++) begin
      wr_ptr = tail_q + rel_off[j];
      if (commit_free_v_i[j]) begin
        entry_d[wr_ptr[IW-1:0]] = commit_free_preg_i[j*PA +: PA];
      end
    end
    tail_d     = tail_q + n_rel;
    chead_d    = chead_q + n_com;
    // Head rewinds to the committed head including this cycle's retirements
    if (flush_i) begin
      head_d = chead_q + n_com;
    end else if (alloc_ready_o) begin
      head_d = head_q + n_req;
    end else begin
      head_d = head_q;
    end
    rel_total  = {1'b0, count} + {1'b0, n_rel};
    overflow_d = overflow_q || (rel_total > (PW+1)'(DEPTH));
  end

  // State registers with synchronous reset to a full list of pregs ARCH_REGS..PHYS_REGS-1
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        entry_q[k] <= PA'(ARCH_REGS + k);
      end
      head_q     <= '0;
      chead_q    <= '0;
      tail_q     <= PW'(DEPTH);
      overflow_q <= 1'b0;
    end else begin
      entry_q    <= entry_d;
      head_q     <= head_d;
      chead_q    <= chead_d;
      tail_q     <= tail_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_freelist_ctrl.sv
// Directed bench for freelist_ctrl with hand-computed expected values.
module tb_freelist_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  alloc_req_i;
  logic        alloc_ready_o;
  logic [11:0] freelist_preg_o;
  logic [1:0]  commit_alloc_v_i;
  logic [1:0]  commit_free_v_i;
  logic [11:0] commit_free_preg_i;
  logic        flush_i;
  logic [5:0]  free_count_o;
  logic        overflow_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  freelist_ctrl #(
    .FRONTEND_WIDTH(2),
    .COMMIT_WIDTH(2),
    .PHYS_REGS(64),
    .PHYS_REGS_ADDR_SIZE(6),
    .ARCH_REGS(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .alloc_req_i(alloc_req_i),
    .alloc_ready_o(alloc_ready_o),
    .freelist_preg_o(freelist_preg_o),
    .commit_alloc_v_i(commit_alloc_v_i),
    .commit_free_v_i(commit_free_v_i),
    .commit_free_preg_i(commit_free_preg_i),
    .flush_i(flush_i),
    .free_count_o(free_count_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int slot(input int i);
    return int'(freelist_preg_o[i*6 +: 6]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    alloc_req_i        = '0;
    commit_alloc_v_i   = '0;
    commit_free_v_i    = '0;
    commit_free_preg_i = '0;
    flush_i            = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_count", int'(free_count_o), 32);
    check("rst_ovf", int'(overflow_o), 0);
    check("rst_ready", int'(alloc_ready_o), 1);

    // Three dual grants from a full list
    alloc_req_i = 2'b11;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("dual_ready", int'(alloc_ready_o), 1);
      check("dual_s0", slot(0), 32 + 2*c);
      check("dual_s1", slot(1), 33 + 2*c);
      step();
      check("dual_count", int'(free_count_o), 30 - 2*c);
    end

    // Only slot1 requesting: compacted onto head entry
    do_reset();
    alloc_req_i = 2'b10;
    #1;
    check("s1only_s1", slot(1), 32);
    check("s1only_s0", slot(0), 0);
    step();
    check("s1only_count", int'(free_count_o), 31);
    alloc_req_i = 2'b01;
    #1;
    check("s1only_next", slot(0), 33);
    step();
    check("s1only_count2", int'(free_count_o), 30);

    // Drain to one entry, then all-or-nothing refusal
    alloc_req_i = 2'b11;
    repeat (14) step();
    alloc_req_i = 2'b01;
    step();
    check("drain_count1", int'(free_count_o), 1);
    alloc_req_i = 2'b11;
    #1;
    check("drain_refuse", int'(alloc_ready_o), 0);
    step();
    check("drain_hold", int'(free_count_o), 1);
    alloc_req_i = 2'b01;
    #1;
    check("drain_last_ready", int'(alloc_ready_o), 1);
    check("drain_last_preg", slot(0), 63);
    step();
    check("drain_empty", int'(free_count_o), 0);
    #1;
    check("empty_refuse", int'(alloc_ready_o), 0);

    // Release into empty list alongside a request: no same-cycle bypass
    commit_free_v_i    = 2'b11;
    commit_free_preg_i = {6'd7, 6'd5};
    #1;
    check("nobypass_ready", int'(alloc_ready_o), 0);
    step();
    commit_free_v_i = 2'b00;
    check("rel_count", int'(free_count_o), 2);
    check("rel_ovf", int'(overflow_o), 0);
    #1;
    check("rel_ready", int'(alloc_ready_o), 1);
    check("rel_first", slot(0), 5);
    step();
    check("rel_second", slot(0), 7);
    step();
    check("rel_drained", int'(free_count_o), 0);

    // Flush with two retirements in the same cycle
    do_reset();
    alloc_req_i = 2'b11;
    repeat (3) step();
    check("pre_flush_count", int'(free_count_o), 26);
    commit_alloc_v_i = 2'b11;
    flush_i          = 1'b1;
    #1;
    check("flush_block", int'(alloc_ready_o), 0);
    step();
    alloc_req_i      = 2'b01;
    commit_alloc_v_i = 2'b00;
    flush_i          = 1'b0;
    check("flush_count", int'(free_count_o), 30);
    #1;
    check("flush_regrant", slot(0), 34);
    step();
    check("flush_after", int'(free_count_o), 29);

    // Release into a full list sets sticky overflow; reset clears it
    do_reset();
    commit_free_v_i    = 2'b01;
    commit_free_preg_i = {6'd0, 6'd9};
    step();
    commit_free_v_i = 2'b00;
    check("ovf_set", int'(overflow_o), 1);
    repeat (2) step();
    check("ovf_sticky", int'(overflow_o), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("ovf_cleared", int'(overflow_o), 0);
    check("midrst_count", int'(free_count_o), 32);
    alloc_req_i = 2'b01;
    #1;
    check("midrst_entry0", slot(0), 32);
    check("midrst_ready", int'(alloc_ready_o), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
